// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and widths for the data-memory port.
// FSM state encoding and word/window widths.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int WIN_W  = 64;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    RSP
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port DEPTH x 32 storage.
// Combinational read, synchronous write, no reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Write commits on the edge ending the access cycle.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_port.sv
// dmem_port: 64-bit window responder over a 32-bit single-port array.
// Optional address-range checking enabled by defining DMEM_ERR_EN.
module dmem_port
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [29:0]      req_addr,
  input  logic [WIN_W-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIN_W-1:0] rsp_rdata,
  output logic             rsp_err
);

  state_t            state;
  logic [IDX_W-1:0]  idx0;
  logic [IDX_W-1:0]  idx1;
  logic              lat_we;
  logic [WIN_W-1:0]  lat_wdata;
  logic              err_q;
  logic              err_r;
  logic              addr_err;
  logic [IDX_W-1:0]  arr_idx;
  logic              arr_we;
  logic [WORD_W-1:0] arr_wdata;
  logic [WORD_W-1:0] arr_rdata;

`ifdef DMEM_ERR_EN
  assign addr_err = (req_addr >> IDX_W) != '0;
`else
  logic [29:0] unused_addr_hi;
  assign unused_addr_hi = req_addr >> IDX_W;
  assign addr_err = 1'b0;
`endif

  // Second word wraps naturally in IDX_W bits.
  assign idx1 = idx0 + 1'b1;

  assign req_ready = (state == IDLE) && !rst;
  assign rsp_err   = err_r;

  assign arr_idx   = (state == HI) ? idx1 : idx0;
  assign arr_wdata = (state == HI) ? lat_wdata[63:32]
                                   : lat_wdata[31:0];
  assign arr_we    = lat_we && !err_q &&
                     ((state == LO) || (state == HI));

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .idx   (arr_idx),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  // Request sequencing: accept, low word, high word, response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      err_r     <= 1'b0;
      err_q     <= 1'b0;
      idx0      <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            idx0      <= req_addr[IDX_W-1:0];
            lat_we    <= req_we;
            lat_wdata <= req_wdata;
            err_q     <= addr_err;
            state     <= LO;
          end
        end
        LO: begin
          rsp_rdata[31:0] <= err_q ? '0 : arr_rdata;
          state           <= HI;
        end
        HI: begin
          rsp_rdata[63:32] <= err_q ? '0 : arr_rdata;
          err_r            <= err_q;
          rsp_valid        <= 1'b1;
          state            <= RSP;
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port.sv
// tb_dmem_port: directed self-checking bench for dmem_port.
// Define DMEM_ERR_EN to also exercise address-error responses.
module tb_dmem_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [29:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  int checks   = 0;
  int failures = 0;

  dmem_port #(.DEPTH(1024)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic xfer(input logic we, input logic [29:0] addr,
                      input logic [63:0] wd, output logic [63:0] rd,
                      output logic er, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout addr=%h", addr);
    end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) begin
      checks++; failures++;
      $display("FAIL rsp_timeout addr=%h", addr);
    end
    rd = rsp_rdata;
    er = rsp_err;
    if (rsp_ready) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 64'h0 ||
        rsp_err !== 1'b0 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got v=%b d=%h e=%b r=%b want 0 0 0 0",
               rsp_valid, rsp_rdata, rsp_err, req_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset got r=%b v=%b want 1 0",
               req_ready, rsp_valid);
    end
  endtask

  task automatic test_store_load();
    logic [63:0] rd;
    logic er;
    int lat;
    xfer(1'b1, 30'h12, 64'h00000000_12121212, rd, er, lat);
    xfer(1'b1, 30'h10, 64'h88776655_44332211, rd, er, lat);
    checks++;
    if (lat !== 2) begin
      failures++;
      $display("FAIL store_latency got %0d want 2", lat);
    end
    xfer(1'b0, 30'h10, 64'h0, rd, er, lat);
    checks++;
    if (rd !== 64'h88776655_44332211 || er !== 1'b0) begin
      failures++;
      $display("FAIL load_10 got %h e=%b want 8877665544332211 0", rd, er);
    end
    xfer(1'b0, 30'h11, 64'h0, rd, er, lat);
    checks++;
    if (rd !== 64'h12121212_88776655) begin
      failures++;
      $display("FAIL load_11 got %h want 1212121288776655", rd);
    end
  endtask

  task automatic test_rbw();
    logic [63:0] rd;
    logic er;
    int lat;
    xfer(1'b1, 30'h20, 64'h01234567_89ABCDEF, rd, er, lat);
    xfer(1'b1, 30'h20, 64'hAAAAAAAA_AAAAAAAA, rd, er, lat);
    checks++;
    if (rd !== 64'h01234567_89ABCDEF) begin
      failures++;
      $display("FAIL rbw_old got %h want 0123456789abcdef", rd);
    end
    xfer(1'b0, 30'h20, 64'h0, rd, er, lat);
    checks++;
    if (rd !== 64'hAAAAAAAA_AAAAAAAA) begin
      failures++;
      $display("FAIL rbw_new got %h want aaaaaaaaaaaaaaaa", rd);
    end
  endtask

  task automatic test_wrap();
    logic [63:0] rd;
    logic er;
    int lat;
    xfer(1'b1, 30'h1, 64'h00000000_11110001, rd, er, lat);
    xfer(1'b1, 30'h3FF, 64'hCAFEBABE_DEADBEEF, rd, er, lat);
    checks++;
    if (er !== 1'b0) begin
      failures++;
      $display("FAIL wrap_err got %b want 0", er);
    end
    xfer(1'b0, 30'h3FF, 64'h0, rd, er, lat);
    checks++;
    if (rd !== 64'hCAFEBABE_DEADBEEF) begin
      failures++;
      $display("FAIL wrap_load_top got %h want cafebabedeadbeef", rd);
    end
    xfer(1'b0, 30'h0, 64'h0, rd, er, lat);
    checks++;
    if (rd !== 64'h11110001_CAFEBABE) begin
      failures++;
      $display("FAIL wrap_load_0 got %h want 11110001cafebabe", rd);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] rd;
    logic er;
    int lat;
    int bad;
    rsp_ready = 1'b0;
    xfer(1'b0, 30'h10, 64'h0, rd, er, lat);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 ||
          rsp_rdata !== 64'h88776655_44332211) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL backpressure_hold got %0d bad cycles want 0 (d=%h)",
               bad, rsp_rdata);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_release got v=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] rd;
    logic er;
    int lat;
    int seen;
    xfer(1'b1, 30'h30, 64'h33333333_30303030, rd, er, lat);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 30'h30;
    req_wdata = 64'h44444444_40404040;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_norsp got %0d rsp cycles r=%b want 0 1",
               seen, req_ready);
    end
    xfer(1'b0, 30'h30, 64'h0, rd, er, lat);
    checks++;
    if (rd !== 64'h33333333_40404040) begin
      failures++;
      $display("FAIL reset_mid_mem got %h want 3333333340404040", rd);
    end
  endtask

  task automatic test_addr_hi();
    logic [63:0] rd;
    logic er;
    int lat;
`ifdef DMEM_ERR_EN
    xfer(1'b1, 30'h400, 64'h55555555_66666666, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 64'h0 || lat !== 2) begin
      failures++;
      $display("FAIL err_resp got e=%b d=%h lat=%0d want 1 0 2",
               er, rd, lat);
    end
    xfer(1'b0, 30'h0, 64'h0, rd, er, lat);
    checks++;
    if (rd !== 64'h11110001_CAFEBABE || er !== 1'b0) begin
      failures++;
      $display("FAIL err_nowrite got %h e=%b want 11110001cafebabe 0",
               rd, er);
    end
`else
    xfer(1'b0, 30'h400, 64'h0, rd, er, lat);
    checks++;
    if (rd !== 64'h11110001_CAFEBABE || er !== 1'b0) begin
      failures++;
      $display("FAIL alias_load got %h e=%b want 11110001cafebabe 0",
               rd, er);
    end
`endif
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    test_reset();
    test_store_load();
    test_rbw();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_addr_hi();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
